sap_ctrl_sequencer: RTL and testbench
=====================================

# sap_ctrl_sequencer

Microcoded control sequencer sitting directly upstream of the adder/accumulator datapath. Accepts one 4-bit opcode per valid/ready handshake and drives the datapath's active-low load strobes (nLa, nLb), bus enables (Ea, Eu) and ALU subtract select cycle by cycle. It latches the ALU carry/zero flags after arithmetic operations and halts on HLT.

## Interface
- SETTLE, default 1: cycles Eu is held before the A-load on ADD/SUB (range 1..15)
- clk  in  1  single system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  opcode on instr_opcode is valid
- instr_opcode  in  4  instruction opcode
- instr_ready  out  1  sequencer can accept an opcode this cycle
- alu_cf  in  1  ALU carry flag from datapath
- alu_zf  in  1  ALU zero flag from datapath
- nLa  out  1  load register A, active low
- nLb  out  1  load register B, active low
- Ea  out  1  drive register A onto bus
- Eu  out  1  drive ALU result onto bus
- sub  out  1  ALU subtract select
- out_strobe  out  1  one-cycle pulse while A is on the bus for OUT
- flag_c, flag_z  out  1 each  latched carry/zero flags
- halted  out  1  sticky, set by HLT
- illegal  out  1  sticky, set by undefined opcode

## Operation
- Opcodes: 0 NOP, 1 LDA, 2 LDB, 3 ADD, 4 SUB, 5 OUT, F HLT; 6..E undefined.
- Inactive control word: nLa=1, nLb=1, Ea=0, Eu=0, sub=0, out_strobe=0. Ea and Eu are never both 1.
- States: IDLE, SETTLE, LOAD, OUTPUT, HALT.
- IDLE: instr_ready=1, inactive control word. Accept when instr_valid && instr_ready.
- NOP: accept, stay IDLE.
- LDA / LDB: go to LOAD for one cycle with nLa=0 / nLb=0, respectively. Ea=Eu=0, so the bus carries the external input. Then return to IDLE.
- ADD / SUB: SETTLE for SETTLE cycles with Eu=1 and sub=(op==SUB), using a 4-bit down-counter. Then LOAD for one cycle with Eu=1, sub held and nLa=0. At the end of LOAD, flag_c<=alu_cf and flag_z<=alu_zf. Then return to IDLE.
- OUT: OUTPUT for one cycle with Ea=1 and out_strobe=1, then return to IDLE.
- HLT: go to HALT and set halted=1. instr_ready=0 and the control word stays inactive until rst.
- Undefined opcode: set illegal=1 and behave as NOP. Flags are unchanged.
- Flags change only at the end of ADD/SUB LOAD.

## Timing
- Reset values: state IDLE; instr_ready=1; control word inactive; flag_c=flag_z=0; halted=0; illegal=0; counter=0.
- All outputs are registered except instr_ready, which decodes from the state register.
- Opcode accepted at edge k: the first execute cycle's control word is visible from edge k through edge k+1.
- Occupancy including the accept cycle:
  - NOP / illegal: 1 cycle
  - LDA / LDB / OUT: 2 cycles
  - ADD / SUB: SETTLE+2 cycles
- instr_ready=0 in every non-IDLE state. No opcode is buffered. instr_valid held during busy is taken at the next IDLE cycle.
- rst has priority over everything. Asserted mid-ADD (including during LOAD), the control word is inactive from the next edge and no flag update occurs.
- rst in HALT returns to IDLE and clears halted.
- Back-to-back: an opcode presented with valid in the cycle after the last execute cycle is accepted there, with no dead cycle.

## Structure
- Package sap_pkg holds:
  - opcode localparams
  - state enum
  - control-word struct {nLa, nLb, Ea, Eu, sub, out_strobe} and its CW_IDLE constant
- Sub-module sap_ctrl_decode: combinational (state, latched opcode) → control word. The top contains the state register, SETTLE counter, opcode latch, flag and sticky registers.

## Test plan
- Reset then LDA (opcode 1): nLa=0 for exactly one cycle, one cycle after accept. instr_ready low for 1 cycle. All other controls inactive.
- SETTLE=1, ADD with alu_cf=1, alu_zf=0: Eu=1,sub=0 for 2 cycles, with nLa=0 only in the 2nd. flag_c=1, flag_z=0 afterwards. instr_ready returns after 3 cycles.
- SETTLE=3, SUB with alu_zf=1: Eu=1,sub=1 for 4 cycles, with nLa=0 in the 4th only. flag_z=1.
- Stream LDA,LDB,OUT,NOP with valid held: accepts at cycles 0,2,4,6. out_strobe and Ea pulse once at cycle 5. Ea and Eu never both high.
- Opcode 9, then HLT, then LDA: illegal=1 with no control activity. halted=1, instr_ready stays 0, and LDA is never accepted. rst clears all and returns instr_ready=1.
- rst asserted during ADD LOAD cycle: nLa=1 next cycle, flags remain 0, state IDLE.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared opcodes, FSM encoding and control-word payload for the SAP control sequencer.
package sap_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 4;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDA = 4'h1;
  localparam logic [OP_W-1:0] OP_LDB = 4'h2;
  localparam logic [OP_W-1:0] OP_ADD = 4'h3;
  localparam logic [OP_W-1:0] OP_SUB = 4'h4;
  localparam logic [OP_W-1:0] OP_OUT = 4'h5;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_LOAD   = 3'd2,
    ST_OUTPUT = 3'd3,
    ST_HALT   = 3'd4
  } state_e;

  typedef struct packed {
    logic nla;
    logic nlb;
    logic ea;
    logic eu;
    logic sub;
    logic out_strobe;
  } cw_t;

  localparam cw_t CW_IDLE = '{nla: 1'b1, nlb: 1'b1, ea: 1'b0, eu: 1'b0, sub: 1'b0, out_strobe: 1'b0};

  // ADD and SUB share the settle/load path through the ALU.
  function automatic logic is_arith(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/sap_ctrl_decode.sv
// Combinational map from (state, latched opcode) to the datapath control word.
module sap_ctrl_decode
  import sap_pkg::*;
(
  input  state_e          state,
  input  logic [OP_W-1:0] opcode,
  output cw_t             cw_c
);

  always_comb begin
    cw_c = CW_IDLE;
    unique case (state)
      ST_SETTLE: begin
        cw_c.eu  = 1'b1;
        cw_c.sub = (opcode == OP_SUB);
      end
      ST_LOAD: begin
        if (is_arith(opcode)) begin
          cw_c.eu  = 1'b1;
          cw_c.sub = (opcode == OP_SUB);
          cw_c.nla = 1'b0;
        end else if (opcode == OP_LDA) begin
          cw_c.nla = 1'b0;
        end else if (opcode == OP_LDB) begin
          cw_c.nlb = 1'b0;
        end
      end
      ST_OUTPUT: begin
        cw_c.ea         = 1'b1;
        cw_c.out_strobe = 1'b1;
      end
      default: cw_c = CW_IDLE;
    endcase
  end

endmodule

// File: rtl/sap_ctrl_sequencer.sv
// Microcoded sequencer: accepts one opcode per handshake and drives registered
// datapath strobes; latches ALU flags at the end of ADD/SUB.
module sap_ctrl_sequencer
  import sap_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [OP_W-1:0] instr_opcode,
  output logic            instr_ready,
  input  logic            alu_cf,
  input  logic            alu_zf,
  output logic            nLa,
  output logic            nLb,
  output logic            Ea,
  output logic            Eu,
  output logic            sub,
  output logic            out_strobe,
  output logic            flag_c,
  output logic            flag_z,
  output logic            halted,
  output logic            illegal
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_z_q, flag_z_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  cw_t              cw_q, cw_d;
  logic             accept;

  assign accept = instr_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    flag_c_d  = flag_c_q;
    flag_z_d  = flag_z_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = instr_opcode;
          unique case (instr_opcode)
            OP_NOP: state_d = ST_IDLE;
            OP_LDA, OP_LDB: state_d = ST_LOAD;
            OP_ADD, OP_SUB: begin
              state_d = ST_SETTLE;
              cnt_d   = CNT_W'(SETTLE - 1);
            end
            OP_OUT: state_d = ST_OUTPUT;
            OP_HLT: begin
              state_d  = ST_HALT;
              halted_d = 1'b1;
            end
            default: illegal_d = 1'b1;
          endcase
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_LOAD: begin
        if (is_arith(op_q)) begin
          flag_c_d = alu_cf;
          flag_z_d = alu_zf;
        end
        state_d = ST_IDLE;
      end
      ST_OUTPUT: state_d = ST_IDLE;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Control word is decoded from the next state so it appears on the accept edge.
  sap_ctrl_decode u_decode (
    .state  (state_d),
    .opcode (op_d),
    .cw_c   (cw_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_NOP;
      flag_c_q  <= 1'b0;
      flag_z_q  <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      cw_q      <= CW_IDLE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      flag_c_q  <= flag_c_d;
      flag_z_q  <= flag_z_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      cw_q      <= cw_d;
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign nLa         = cw_q.nla;
  assign nLb         = cw_q.nlb;
  assign Ea          = cw_q.ea;
  assign Eu          = cw_q.eu;
  assign sub         = cw_q.sub;
  assign out_strobe  = cw_q.out_strobe;
  assign flag_c      = flag_c_q;
  assign flag_z      = flag_z_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_sap_ctrl_sequencer.sv
// Directed bench for sap_ctrl_sequencer: two instances (SETTLE=1 and SETTLE=3) share stimulus.
module tb_sap_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic [3:0] instr_opcode;
  logic       alu_cf, alu_zf;

  logic a_ready, a_nla, a_nlb, a_ea, a_eu, a_sub, a_out, a_fc, a_fz, a_halt, a_ill;
  logic b_ready, b_nla, b_nlb, b_ea, b_eu, b_sub, b_out, b_fc, b_fz, b_halt, b_ill;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sap_ctrl_sequencer #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_opcode(instr_opcode),
    .instr_ready(a_ready), .alu_cf(alu_cf), .alu_zf(alu_zf),
    .nLa(a_nla), .nLb(a_nlb), .Ea(a_ea), .Eu(a_eu), .sub(a_sub), .out_strobe(a_out),
    .flag_c(a_fc), .flag_z(a_fz), .halted(a_halt), .illegal(a_ill)
  );

  sap_ctrl_sequencer #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_opcode(instr_opcode),
    .instr_ready(b_ready), .alu_cf(alu_cf), .alu_zf(alu_zf),
    .nLa(b_nla), .nLb(b_nlb), .Ea(b_ea), .Eu(b_eu), .sub(b_sub), .out_strobe(b_out),
    .flag_c(b_fc), .flag_z(b_fz), .halted(b_halt), .illegal(b_ill)
  );

  // Control word packed as {nLa,nLb,Ea,Eu,sub,out_strobe}
  wire [5:0] a_cw = {a_nla, a_nlb, a_ea, a_eu, a_sub, a_out};
  wire [5:0] b_cw = {b_nla, b_nlb, b_ea, b_eu, b_sub, b_out};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; instr_valid = 1'b0; instr_opcode = 4'h0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (a_cw !== 6'b110000 || a_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_cw: cw=%b ready=%b want cw=110000 ready=1", a_cw, a_ready);
    end
    n_tests++;
    if ({a_fc, a_fz, a_halt, a_ill} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_status: fc,fz,halt,ill=%b want 0000", {a_fc, a_fz, a_halt, a_ill});
    end
  endtask

  task automatic test_lda();
    do_reset();
    instr_valid = 1'b1; instr_opcode = 4'h1;
    tick();
    instr_valid = 1'b0;
    n_tests++;
    if (a_cw !== 6'b010000 || a_ready !== 1'b0) begin
      n_fail++; $display("FAIL lda_load: cw=%b ready=%b want cw=010000 ready=0", a_cw, a_ready);
    end
    tick();
    n_tests++;
    if (a_cw !== 6'b110000 || a_ready !== 1'b1) begin
      n_fail++; $display("FAIL lda_done: cw=%b ready=%b want cw=110000 ready=1", a_cw, a_ready);
    end
  endtask

  task automatic test_add_settle1();
    logic [5:0] exp_cw [3] = '{6'b110100, 6'b010100, 6'b110000};
    logic       exp_rdy[3] = '{1'b0, 1'b0, 1'b1};
    do_reset();
    alu_cf = 1'b1; alu_zf = 1'b0;
    instr_valid = 1'b1; instr_opcode = 4'h3;
    tick();
    instr_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (a_cw !== exp_cw[i] || a_ready !== exp_rdy[i]) begin
        n_fail++;
        $display("FAIL add_cycle%0d: cw=%b ready=%b want cw=%b ready=%b", i, a_cw, a_ready, exp_cw[i], exp_rdy[i]);
      end
      if (i < 2) tick();
    end
    n_tests++;
    if ({a_fc, a_fz} !== 2'b10) begin
      n_fail++; $display("FAIL add_flags: fc,fz=%b want 10", {a_fc, a_fz});
    end
  endtask

  task automatic test_sub_settle3();
    do_reset();
    alu_cf = 1'b0; alu_zf = 1'b1;
    instr_valid = 1'b1; instr_opcode = 4'h4;
    tick();
    instr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [5:0] ecw;
      logic       erdy;
      ecw  = (i < 3) ? 6'b110110 : (i == 3) ? 6'b010110 : 6'b110000;
      erdy = (i == 4);
      n_tests++;
      if (b_cw !== ecw || b_ready !== erdy) begin
        n_fail++;
        $display("FAIL sub_cycle%0d: cw=%b ready=%b want cw=%b ready=%b", i, b_cw, b_ready, ecw, erdy);
      end
      if (i < 4) tick();
    end
    n_tests++;
    if ({b_fc, b_fz} !== 2'b01) begin
      n_fail++; $display("FAIL sub_flags: fc,fz=%b want 01", {b_fc, b_fz});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops  [8] = '{4'h1, 4'h2, 4'h2, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0};
    logic       rdy  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [5:0] cw   [8] = '{6'b110000, 6'b010000, 6'b110000, 6'b100000,
                             6'b110000, 6'b111001, 6'b110000, 6'b110000};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      instr_valid  = (c < 7);
      instr_opcode = ops[c];
      n_tests++;
      if (a_cw !== cw[c] || a_ready !== rdy[c] || (a_ea && a_eu)) begin
        n_fail++;
        $display("FAIL stream_cycle%0d: cw=%b ready=%b want cw=%b ready=%b", c, a_cw, a_ready, cw[c], rdy[c]);
      end
      tick();
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_illegal_halt();
    do_reset();
    instr_valid = 1'b1; instr_opcode = 4'h9;
    tick();
    n_tests++;
    if (a_ill !== 1'b1 || a_cw !== 6'b110000 || a_ready !== 1'b1 || {a_fc, a_fz} !== 2'b00) begin
      n_fail++;
      $display("FAIL illegal: ill=%b cw=%b ready=%b want ill=1 cw=110000 ready=1", a_ill, a_cw, a_ready);
    end
    instr_opcode = 4'hF;
    tick();
    n_tests++;
    if (a_halt !== 1'b1 || a_ready !== 1'b0 || a_cw !== 6'b110000) begin
      n_fail++;
      $display("FAIL halt: halt=%b ready=%b cw=%b want halt=1 ready=0 cw=110000", a_halt, a_ready, a_cw);
    end
    instr_opcode = 4'h1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (a_ready !== 1'b0 || a_cw !== 6'b110000 || a_halt !== 1'b1) begin
        n_fail++;
        $display("FAIL halt_hold%0d: ready=%b cw=%b halt=%b want ready=0 cw=110000 halt=1", i, a_ready, a_cw, a_halt);
      end
    end
    do_reset();
    n_tests++;
    if ({a_halt, a_ill, a_ready} !== 3'b001) begin
      n_fail++; $display("FAIL halt_reset: halt,ill,ready=%b want 001", {a_halt, a_ill, a_ready});
    end
  endtask

  task automatic test_rst_in_load();
    do_reset();
    alu_cf = 1'b1; alu_zf = 1'b1;
    instr_valid = 1'b1; instr_opcode = 4'h3;
    tick();
    instr_valid = 1'b0;
    tick();
    n_tests++;
    if (a_nla !== 1'b0) begin
      n_fail++; $display("FAIL rst_load_pre: nLa=%b want 0", a_nla);
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if (a_cw !== 6'b110000 || {a_fc, a_fz} !== 2'b00 || a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_load: cw=%b flags=%b ready=%b want cw=110000 flags=00 ready=1", a_cw, {a_fc, a_fz}, a_ready);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if ({a_fc, a_fz} !== 2'b00 || a_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_load_after: flags=%b ready=%b want flags=00 ready=1", {a_fc, a_fz}, a_ready);
    end
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr_opcode = 4'h0; alu_cf = 1'b0; alu_zf = 1'b0;
    test_reset();
    test_lda();
    test_add_settle1();
    test_sub_settle3();
    test_back_to_back();
    test_illegal_halt();
    test_rst_in_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
